// File: rtl/cheri_pkg.sv
// Shared CHERI register-file types: capability metadata, sweep FSM states and
// address helpers used by cheri_regfile_mp and its reservation counters.
package cheri_pkg;

   localparam int RF_MAX_NRD = 4;

   typedef struct packed {
      logic        valid;
      logic [11:0] perms;
      logic [3:0]  otype;
      logic [5:0]  cexp;
   } reg_cap_t;

   localparam reg_cap_t NULL_REG_CAP = '{valid: 1'b0, perms: 12'h000, otype: 4'h0, cexp: 6'h00};

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } rf_sweep_state_e;

   // x0 is hard-wired, so it never counts as a storage location.
   function automatic logic rf_addr_in_range(input logic [4:0] addr, input int lim);
      return (addr != 5'd0) && (int'(addr) < lim);
   endfunction

endpackage

// File: rtl/cheri_rf_rsv_ctr.sv
// Saturating up/down counter tracking outstanding capability loads on one register.
module cheri_rf_rsv_ctr #(
   parameter int MaxPend = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic full_o
);

   localparam int                  CntWidth = $clog2(MaxPend + 1);
   localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxPend);

   logic [CntWidth-1:0] cnt_q;

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // flop samples the values that existed before the clock edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (inc_i && !dec_i && !full_o) begin
         cnt_q <= cnt_q + CntWidth'(1);
      end else if (dec_i && !inc_i && !zero_o) begin
         cnt_q <= cnt_q - CntWidth'(1);
      end
   end

   assign zero_o = (cnt_q == '0);
   assign full_o = (cnt_q == CntMax);

endmodule

// File: rtl/cheri_regfile_mp.sv
// Multi-read-port CHERI register file with load reservations and tag-clear sweep.
// Define CHERI_RF_PARITY_EN to store and check one even-parity bit per register.
module cheri_regfile_mp
   import cheri_pkg::*;
#(
   parameter int NREGS     = 32,
   parameter int NCAPS     = 32,
   parameter int NRD       = 2,
   parameter int DataWidth = 32,
   parameter int MaxPend   = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NRD-1:0][4:0]           raddr_i,
   output logic [NRD-1:0][DataWidth-1:0] rdata_o,
   output reg_cap_t [NRD-1:0]            rcap_o,
   input  logic [4:0]                    waddr_i,
   input  logic [DataWidth-1:0]          wdata_i,
   input  reg_cap_t                      wcap_i,
   input  logic                          we_i,
   input  logic                          trsv_en_i,
   input  logic [4:0]                    trsv_addr_i,
   output logic                          trsv_rdy_o,
   input  logic                          trvk_en_i,
   input  logic [4:0]                    trvk_addr_i,
   input  logic                          trvk_clrtag_i,
   output logic [31:0]                   reg_rdy_o,
   input  logic                          sweep_req_i,
   output logic                          sweep_busy_o,
   output logic                          sweep_ack_o,
   output logic [NRD-1:0]                par_err_o
);

   localparam int RF_DEPTH = 32;

   logic [DataWidth-1:0] rf_data [RF_DEPTH];
   reg_cap_t             rf_cap  [RF_DEPTH];
   logic [RF_DEPTH-1:0]  tag_clr;
   logic [RF_DEPTH-1:0]  rsv_zero;
   logic [RF_DEPTH-1:0]  rsv_full;
   rf_sweep_state_e      state_q, state_d;
   logic [4:0]           idx_q, idx_d;

   // ---------------- sweep FSM ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sweep_ack_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sweep_req_i) begin
               state_d = SWEEP;
               idx_d   = 5'd1;
            end
         end
         SWEEP: begin
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'(NCAPS - 1)) state_d = DONE;
         end
         DONE: begin
            sweep_ack_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sweep_busy_o = (state_q != IDLE);

   // Tag clear wins over a same-cycle write; the rest of the write still lands.
   always_comb begin
      tag_clr = '0;
      for (int i = 1; i < NCAPS; i++) begin
         tag_clr[i] = ((state_q == SWEEP) && (idx_q == 5'(i))) ||
                      (trvk_en_i && trvk_clrtag_i && (trvk_addr_i == 5'(i)));
      end
   end

   // ---------------- storage ----------------
   // NOTE: the array is reset explicitly because software relies on every register
   // reading zero / NULL after reset; this costs a reset net on each storage flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < RF_DEPTH; i++) begin
            rf_data[i] <= '0;
            rf_cap[i]  <= NULL_REG_CAP;
         end
      end else begin
         if (we_i && rf_addr_in_range(waddr_i, NREGS)) rf_data[waddr_i] <= wdata_i;
         for (int i = 1; i < NCAPS; i++) begin
            if (we_i && (waddr_i == 5'(i))) rf_cap[i] <= wcap_i;
            if (tag_clr[i]) rf_cap[i].valid <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rdata_o[p] = '0;
         rcap_o[p]  = NULL_REG_CAP;
         if (rf_addr_in_range(raddr_i[p], NREGS)) rdata_o[p] = rf_data[raddr_i[p]];
         if (rf_addr_in_range(raddr_i[p], NCAPS)) rcap_o[p]  = rf_cap[raddr_i[p]];
      end
   end

`ifdef CHERI_RF_PARITY_EN
   logic [RF_DEPTH-1:0] rf_par;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_par <= '0;
      end else if (we_i && rf_addr_in_range(waddr_i, NREGS)) begin
         rf_par[waddr_i] <= ^wdata_i;
      end
   end

   always_comb begin
      par_err_o = '0;
      for (int p = 0; p < NRD; p++) begin
         if (rf_addr_in_range(raddr_i[p], NREGS)) begin
            par_err_o[p] = (^rf_data[raddr_i[p]]) != rf_par[raddr_i[p]];
         end
      end
   end
`else
   assign par_err_o = '0;
`endif

   // ---------------- reservations ----------------
   for (genvar g = 0; g < RF_DEPTH; g++) begin : g_rsv
      if ((g >= 1) && (g < NCAPS)) begin : g_ctr
         cheri_rf_rsv_ctr #(
            .MaxPend(MaxPend)
         ) u_ctr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (trsv_en_i && (trsv_addr_i == 5'(g))),
            .dec_i (trvk_en_i && (trvk_addr_i == 5'(g))),
            .zero_o(rsv_zero[g]),
            .full_o(rsv_full[g])
         );
      end else begin : g_tie
         assign rsv_zero[g] = 1'b1;
         assign rsv_full[g] = 1'b0;
      end
   end

   assign reg_rdy_o  = rsv_zero;
   assign trsv_rdy_o = !rsv_full[trsv_addr_i];

endmodule

// File: tb/tb_cheri_regfile_mp.sv
// Self-checking bench for cheri_regfile_mp: read expectations go through a scoreboard
// queue filled from a small register model when reads are driven.
module tb_cheri_regfile_mp;
   import cheri_pkg::*;

   localparam int NREGS = 32;
   localparam int NCAPS = 32;
   localparam int NRD   = 2;
   localparam int DW    = 32;
   localparam int MAXP  = 3;

   logic                   clk = 1'b0;
   logic                   rst_i;
   logic [NRD-1:0][4:0]    raddr_i;
   logic [NRD-1:0][DW-1:0] rdata_o;
   reg_cap_t [NRD-1:0]     rcap_o;
   logic [4:0]             waddr_i;
   logic [DW-1:0]          wdata_i;
   reg_cap_t               wcap_i;
   logic                   we_i;
   logic                   trsv_en_i;
   logic [4:0]             trsv_addr_i;
   logic                   trsv_rdy_o;
   logic                   trvk_en_i;
   logic [4:0]             trvk_addr_i;
   logic                   trvk_clrtag_i;
   logic [31:0]            reg_rdy_o;
   logic                   sweep_req_i;
   logic                   sweep_busy_o;
   logic                   sweep_ack_o;
   logic [NRD-1:0]         par_err_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] m_data  [32];
   logic          m_valid [32];

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;
   exp_t sb[$];

   cheri_regfile_mp #(
      .NREGS(NREGS), .NCAPS(NCAPS), .NRD(NRD), .DataWidth(DW), .MaxPend(MAXP)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .raddr_i      (raddr_i),
      .rdata_o      (rdata_o),
      .rcap_o       (rcap_o),
      .waddr_i      (waddr_i),
      .wdata_i      (wdata_i),
      .wcap_i       (wcap_i),
      .we_i         (we_i),
      .trsv_en_i    (trsv_en_i),
      .trsv_addr_i  (trsv_addr_i),
      .trsv_rdy_o   (trsv_rdy_o),
      .trvk_en_i    (trvk_en_i),
      .trvk_addr_i  (trvk_addr_i),
      .trvk_clrtag_i(trvk_clrtag_i),
      .reg_rdy_o    (reg_rdy_o),
      .sweep_req_i  (sweep_req_i),
      .sweep_busy_o (sweep_busy_o),
      .sweep_ack_o  (sweep_ack_o),
      .par_err_o    (par_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [63:0] got);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   function automatic reg_cap_t mk_cap(input logic v);
      reg_cap_t c;
      c.valid = v;
      c.perms = 12'hABC;
      c.otype = 4'h3;
      c.cexp  = 6'h07;
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_data[i]  = '0;
         m_valid[i] = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      we_i = 1'b0; waddr_i = '0; wdata_i = '0; wcap_i = NULL_REG_CAP;
      trsv_en_i = 1'b0; trsv_addr_i = '0;
      trvk_en_i = 1'b0; trvk_addr_i = '0; trvk_clrtag_i = 1'b0;
      sweep_req_i = 1'b0;
   endtask

   // Expectations come from the model as the read is driven; the DUT answer is
   // sampled one time unit later and matched in order.
   task automatic read_ports(input logic [NRD-1:0][4:0] ra, input logic [NRD-1:0] exp_par,
                             input string tag);
      raddr_i = ra;
      for (int p = 0; p < NRD; p++) begin
         push_exp($sformatf("%s_data%0d", tag, p), 64'(m_data[ra[p]]));
         push_exp($sformatf("%s_valid%0d", tag, p), 64'(m_valid[ra[p]]));
         push_exp($sformatf("%s_par%0d", tag, p), 64'(exp_par[p]));
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
         pop_check(64'(rdata_o[p]));
         pop_check(64'(rcap_o[p].valid));
         pop_check(64'(par_err_o[p]));
      end
   endtask

   task automatic read_all(input logic [4:0] a, input string tag);
      logic [NRD-1:0][4:0] ra;
      for (int p = 0; p < NRD; p++) ra[p] = a;
      read_ports(ra, '0, tag);
   endtask

   task automatic wr(input logic [4:0] a, input logic [DW-1:0] d, input logic v);
      we_i = 1'b1; waddr_i = a; wdata_i = d; wcap_i = mk_cap(v);
      step();
      we_i = 1'b0;
      if (a != 5'd0) begin
         m_data[a]  = d;
         m_valid[a] = v;
      end
   endtask

   task automatic rsv(input logic [4:0] a);
      trsv_en_i = 1'b1; trsv_addr_i = a;
      step();
      trsv_en_i = 1'b0;
   endtask

   task automatic rvk(input logic [4:0] a, input logic clr);
      trvk_en_i = 1'b1; trvk_addr_i = a; trvk_clrtag_i = clr;
      step();
      trvk_en_i = 1'b0; trvk_clrtag_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_cycle;
      int n_ack;
      logic [NRD-1:0][4:0] ra;
      logic [NRD-1:0]      par_exp;

      idle_inputs();
      raddr_i = '0;
      rst_i   = 1'b1;
      m_reset();
      step();
      step();
      rst_i = 1'b0;

      // Reset state
      check("rst_reg_rdy", 64'(reg_rdy_o), 64'hFFFF_FFFF);
      check("rst_busy", 64'(sweep_busy_o), 64'd0);
      check("rst_ack", 64'(sweep_ack_o), 64'd0);
      trsv_addr_i = 5'd9;
      #1;
      check("rst_trsv_rdy", 64'(trsv_rdy_o), 64'd1);
      read_all(5'd5, "rst_x5");

      // Write x5; same-cycle read sees the old value
      we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'h1234_5678; wcap_i = mk_cap(1'b1);
      read_all(5'd5, "x5_old");
      step();
      we_i = 1'b0;
      m_data[5] = 32'h1234_5678; m_valid[5] = 1'b1;
      read_all(5'd5, "x5_new");
      check("x5_perms", 64'(rcap_o[NRD-1].perms), 64'hABC);

      // x0 stays zero with NULL cap
      wr(5'd0, 32'hDEAD_BEEF, 1'b1);
      read_all(5'd0, "x0");

      // Reservations on x9 saturate at MaxPend
      rsv(5'd9);
      check("rsv1_rdy9", 64'(reg_rdy_o[9]), 64'd0);
      rsv(5'd9);
      trsv_addr_i = 5'd9;
      #1;
      check("rsv2_trsv_rdy", 64'(trsv_rdy_o), 64'd1);
      rsv(5'd9);
      trsv_addr_i = 5'd9;
      #1;
      check("rsv3_trsv_rdy", 64'(trsv_rdy_o), 64'd0);
      check("rsv3_reg_rdy", 64'(reg_rdy_o), 64'hFFFF_FDFF);
      rsv(5'd9);
      rvk(5'd9, 1'b0);
      rvk(5'd9, 1'b0);
      check("rvk2_rdy9", 64'(reg_rdy_o[9]), 64'd0);
      rvk(5'd9, 1'b0);
      check("rvk3_rdy9", 64'(reg_rdy_o[9]), 64'd1);
      rvk(5'd9, 1'b0);
      rsv(5'd9);
      check("no_underflow_rsv", 64'(reg_rdy_o[9]), 64'd0);
      rvk(5'd9, 1'b0);
      check("no_underflow_rvk", 64'(reg_rdy_o[9]), 64'd1);

      // Same-cycle reserve and retire on x9 holds the count
      rsv(5'd9);
      trsv_en_i = 1'b1; trsv_addr_i = 5'd9;
      trvk_en_i = 1'b1; trvk_addr_i = 5'd9;
      step();
      trsv_en_i = 1'b0; trvk_en_i = 1'b0;
      check("same_cycle_hold", 64'(reg_rdy_o[9]), 64'd0);
      rvk(5'd9, 1'b0);
      check("same_cycle_release", 64'(reg_rdy_o[9]), 64'd1);

      // Tag clear beats a same-cycle write, data still written
      wr(5'd9, 32'h0000_9999, 1'b1);
      trvk_en_i = 1'b1; trvk_addr_i = 5'd9; trvk_clrtag_i = 1'b1;
      wr(5'd9, 32'hA5A5_A5A5, 1'b1);
      trvk_en_i = 1'b0; trvk_clrtag_i = 1'b0;
      m_valid[9] = 1'b0;
      read_all(5'd9, "clrtag_wr_x9");
      check("clrtag_rdy9", 64'(reg_rdy_o[9]), 64'd1);
      wr(5'd11, 32'h0000_1111, 1'b1);
      rvk(5'd11, 1'b1);
      m_valid[11] = 1'b0;
      read_all(5'd11, "clrtag_x11");

      // Parity: mixed-port read of x7 and x5
      wr(5'd7, 32'h0000_00F0, 1'b1);
`ifdef CHERI_RF_PARITY_EN
      dut.rf_data[7] = 32'h0000_00F1;
      m_data[7]      = 32'h0000_00F1;
      par_exp        = 2'b01;
`else
      par_exp        = 2'b00;
`endif
      ra[0] = 5'd7;
      ra[1] = 5'd5;
      read_ports(ra, par_exp, "par_mixed");

      // Sweep over a register file full of valid caps
      for (int i = 1; i < 32; i++) wr(5'(i), DW'(32'h0101_0101 * i), 1'b1);
      read_all(5'd31, "fill_x31");
      sweep_req_i = 1'b1;
      step();
      sweep_req_i = 1'b0;
      check("sweep_busy_rise", 64'(sweep_busy_o), 64'd1);
      ack_cycle = 0;
      n_ack     = 0;
      for (int c = 1; c <= 40; c++) begin
         if (sweep_ack_o) begin
            n_ack++;
            if (ack_cycle == 0) ack_cycle = c;
         end
         if (c == NCAPS) check("busy_in_done", 64'(sweep_busy_o), 64'd1);
         if (c == NCAPS + 1) check("busy_fall", 64'(sweep_busy_o), 64'd0);
         sweep_req_i = (c == 5);
         if (c == 10) begin
            we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'hCAFE_0003; wcap_i = mk_cap(1'b1);
         end else begin
            we_i = 1'b0;
         end
         step();
      end
      sweep_req_i = 1'b0;
      we_i        = 1'b0;
      check("ack_cycle", 64'(ack_cycle), 64'(NCAPS));
      check("ack_count", 64'(n_ack), 64'd1);
      for (int i = 1; i < 32; i++) m_valid[i] = 1'b0;
      m_data[3]  = 32'hCAFE_0003;
      m_valid[3] = 1'b1;
      for (int i = 1; i < 32; i++) read_all(5'(i), $sformatf("swept_x%0d", i));

      // Reset at sweep cycle 5 aborts with no ack and clears reservations
      wr(5'd20, 32'h0000_2020, 1'b1);
      rsv(5'd12);
      sweep_req_i = 1'b1;
      step();
      sweep_req_i = 1'b0;
      for (int c = 1; c < 5; c++) step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      m_reset();
      check("abort_busy", 64'(sweep_busy_o), 64'd0);
      n_ack = 0;
      for (int c = 0; c < 40; c++) begin
         if (sweep_ack_o) n_ack++;
         step();
      end
      check("abort_ack_count", 64'(n_ack), 64'd0);
      check("abort_reg_rdy", 64'(reg_rdy_o), 64'hFFFF_FFFF);
      read_all(5'd20, "abort_x20");

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cheri_regfile_mp.md
# cheri_regfile_mp

Parametrised multi-read-port CHERI register file, successor to the single-outstanding-load capability register file. It holds integer data and capability metadata, and tracks multiple outstanding capability loads per register with saturating reservation counters. It also runs a background tag-clear sweep for compartment/context switch, and optionally stores a per-register parity bit. It sits in the ID/WB boundary of the core and feeds operand read and load-scoreboard logic.

## Interface
- NREGS, 32, number of integer registers (16 or 32)
- NCAPS, 32, registers carrying capability metadata (≤ NREGS)
- NRD, 2, read ports (2..4)
- DataWidth, 32, data width
- MaxPend, 3, max outstanding reservations per register (1..7)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- raddr_i  in  NRD×5  read addresses
- rdata_o  out  NRD×DataWidth  read data
- rcap_o  out  NRD×reg_cap_t  read capability metadata
- waddr_i / wdata_i / wcap_i / we_i  in  5 / DataWidth / reg_cap_t / 1  write port; data and cap always written together
- trsv_en_i, trsv_addr_i  in  1, 5  reserve register for an outstanding load
- trsv_rdy_o  out  1  reservation at trsv_addr_i will be accepted
- trvk_en_i, trvk_addr_i, trvk_clrtag_i  in  1, 5, 1  retire reservation; optionally clear tag
- reg_rdy_o  out  32  bit i = register i has no outstanding reservation
- sweep_req_i  in  1  start tag-clear sweep
- sweep_busy_o  out  1  sweep in progress
- sweep_ack_o  out  1  one-cycle pulse, sweep complete
- par_err_o  out  NRD  per-port parity mismatch

## Operation
- x0 reads data 0 and NULL_REG_CAP. Registers ≥ NCAPS read NULL_REG_CAP for capability metadata.
- Reservation counter per register 1..NCAPS-1, width $clog2(MaxPend+1).
  - trsv increments the counter; trvk decrements it.
  - trsv and trvk on the same register in the same cycle: counter unchanged.
  - trsv when counter == MaxPend: ignored. trsv_rdy_o = 0 for that address.
  - trvk when counter == 0: ignored. Counter never underflows.
  - reg_rdy_o[i] = (counter == 0). Bits 0 and ≥ NCAPS are tied to 1.
- Cap valid next-state priority, per register:
  - sweep hit or (trvk_en_i & trvk_clrtag_i & address hit) → valid = 0;
  - else a write loads wcap_i.
  - Other cap fields and data follow the write normally.
- Sweep FSM:
  - IDLE: sweep_req_i → SWEEP with idx = 1.
  - SWEEP: clears valid of rf_cap[idx] each cycle and increments idx. After idx == NCAPS-1 → DONE.
  - DONE: sweep_ack_o = 1 for one cycle → IDLE.
  - sweep_req_i is ignored while busy.
  - Reservations and writes continue during a sweep. A write to a register already swept keeps its written tag.

## Timing
- Reads: combinational from address to data, cap and par_err. No write-to-read bypass; a write is visible the cycle after we_i.
- Reservation and reg_rdy updates: visible the cycle after trsv/trvk.
- Sweep: busy rises the cycle after the accepted req. Ack arrives NCAPS cycles after acceptance (NCAPS-1 SWEEP cycles plus 1 DONE). Busy stays high through DONE.
- Reset values:
  - data 0, parity 0, caps NULL_REG_CAP;
  - counters 0, reg_rdy_o all 1;
  - FSM IDLE, sweep_busy_o 0, sweep_ack_o 0.
- Reset mid-sweep aborts the sweep with no ack.

## Configuration
- CHERI_RF_PARITY_EN defined:
  - one even-parity bit per register, computed over wdata_i on write;
  - each read port recomputes parity and flags a mismatch on par_err_o[p];
  - x0 is never flagged.
- CHERI_RF_PARITY_EN undefined: no parity storage; par_err_o tied to 0.

## Structure
- cheri_pkg additions:
  - rf_sweep_state_e (IDLE, SWEEP, DONE);
  - RF_MAX_NRD = 4;
  - reuse of existing reg_cap_t and NULL_REG_CAP.
- One sub-module, cheri_rf_rsv_ctr: a saturating up/down counter with simultaneous inc/dec handling and a zero flag, instantiated per capability register.

## Test plan
- Write x5 = 0x1234_5678 with a valid cap; read on all NRD ports the next cycle → data matches and rcap.valid = 1; the same-cycle read returns the old value.
- Reserve x9 three times with MaxPend = 3 → reg_rdy_o[9] = 0, trsv_rdy_o = 0, and a fourth trsv is ignored; three trvk → reg_rdy_o[9] = 1; a further trvk leaves the counter at 0.
- Same-cycle trsv and trvk on x9 with counter 1 → counter stays 1; trvk with clrtag on x9 alongside a valid write to x9 → valid = 0, data written.
- Fill regs 1..31 with valid caps; pulse sweep_req_i → busy the next cycle, ack exactly 32 cycles after req, all valid = 0. A write to x3 at sweep cycle 10 keeps its tag. Reset at sweep cycle 5 → IDLE with no ack.
- CHERI_RF_PARITY_EN: force a stored data bit of x7 via backdoor → par_err_o set on the port reading x7, 0 on the others. Without the macro → par_err_o = 0.
